// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter stream checker: checker state encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package counter_checker_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_ERR_W    = 16;
    localparam int DEF_MAX_MISS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        RST_HOLD = 2'd2
    } chk_state_t;

endpackage

// File: rtl/counter_checker_satcnt.sv
// Saturating up-counter; increments on inc and sticks at all-ones.
// Latency: count reflects inc one clock later.
// Backpressure: none; inc is accepted every cycle, saturation silently drops increments.
module counter_checker_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Locks onto a free-running counter stream, predicts each next value and flags deviations.
// Latency: all outputs registered, updated on the edge that samples the offending value.
// Backpressure: none; passive monitor. Optional first-error capture via COUNTER_CHECKER_FIRST_ERR_EN.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int MAX_MISS = DEF_MAX_MISS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    input  logic             cnt_rst,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
`endif
    output logic [WIDTH-1:0] expected
);

    localparam int                MISS_W   = $clog2(MAX_MISS + 1);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MAX_MISS);

    chk_state_t        state, state_nxt;
    logic [WIDTH-1:0]  exp_nxt;
    logic [WIDTH-1:0]  cmp_exp;
    logic [MISS_W-1:0] miss, miss_nxt, miss_inc;
    logic              mis;

    always_comb begin
        state_nxt = state;
        exp_nxt   = expected;
        miss_nxt  = miss;
        mis       = 1'b0;
        // While the counter is held in reset the only legal value is zero.
        cmp_exp   = (state == RST_HOLD) ? '0 : expected;
        miss_inc  = miss + 1'b1;

        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt_rst) begin
                        state_nxt = RST_HOLD;
                        exp_nxt   = '0;
                    end else begin
                        state_nxt = TRACK;
                        exp_nxt   = value + 1'b1;
                    end
                end
                TRACK: begin
                    // The value seen with cnt_rst predates the counter's reset, so it is not judged.
                    if (cnt_rst) begin
                        state_nxt = RST_HOLD;
                        exp_nxt   = '0;
                    end else if (value == cmp_exp) begin
                        exp_nxt  = expected + 1'b1;
                        miss_nxt = '0;
                    end else begin
                        mis      = 1'b1;
                        exp_nxt  = value + 1'b1;
                        miss_nxt = miss_inc;
                    end
                end
                RST_HOLD: begin
                    state_nxt = cnt_rst ? RST_HOLD : TRACK;
                    exp_nxt   = cnt_rst ? '0 : WIDTH'(1);
                    if (value == cmp_exp) begin
                        miss_nxt = '0;
                    end else begin
                        mis      = 1'b1;
                        miss_nxt = miss_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            // Too many consecutive misses: give up and relock from scratch.
            if (mis && (miss_inc >= MISS_LIM)) begin
                state_nxt = IDLE;
                miss_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            expected <= '0;
            miss     <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            expected <= exp_nxt;
            miss     <= miss_nxt;
            locked   <= (state_nxt != IDLE);
            err      <= mis;
        end
    end

    counter_checker_satcnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mis),
        .count (err_count)
    );

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    logic first_seen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_seen <= 1'b0;
            first_exp  <= '0;
            first_act  <= '0;
        end else if (mis && !first_seen) begin
            first_seen <= 1'b1;
            first_exp  <= cmp_exp;
            first_act  <= value;
        end
    end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Randomized and directed stimulus for counter_checker against a behavioural stream model.
module tb_counter_checker;

    localparam int ERR_W    = 4;
    localparam int MAX_MISS = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_TRK  = 1;
    localparam int M_HOLD = 2;

    logic             clk;
    logic             reset;
    logic             en;
    logic [7:0]       value;
    logic             cnt_rst;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       expected;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    logic [7:0]       first_exp;
    logic [7:0]       first_act;
`endif

    counter_checker #(
        .WIDTH    (8),
        .ERR_W    (ERR_W),
        .MAX_MISS (MAX_MISS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .value     (value),
        .cnt_rst   (cnt_rst),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        .first_exp (first_exp),
        .first_act (first_act),
`endif
        .expected  (expected)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // reference model of what the checker should report
    int m_mode, m_exp, m_miss, m_cnt, m_err, m_locked;
    int m_fexp, m_fact, m_fseen;
    int ctr;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_exp = 0; m_miss = 0; m_cnt = 0; m_err = 0; m_locked = 0;
        m_fexp = 0; m_fact = 0; m_fseen = 0;
    endfunction

    function automatic void model_miss(input int want, input int got);
        m_err = 1;
        if (m_cnt < ERR_MAX) m_cnt++;
        if (!m_fseen) begin
            m_fseen = 1; m_fexp = want; m_fact = got;
        end
        m_miss++;
    endfunction

    function automatic void model_edge(input bit e, input bit cr, input int v);
        m_err = 0;
        if (!e) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = cr ? M_HOLD : M_TRK;
            m_exp  = cr ? 0 : (v + 1) % 256;
        end else if (m_mode == M_TRK) begin
            if (cr) begin
                m_mode = M_HOLD; m_exp = 0;
            end else if (v == m_exp) begin
                m_exp = (m_exp + 1) % 256; m_miss = 0;
            end else begin
                model_miss(m_exp, v);
                m_exp = (v + 1) % 256;
            end
        end else begin
            if (v == 0) m_miss = 0;
            else        model_miss(0, v);
            m_mode = cr ? M_HOLD : M_TRK;
            m_exp  = cr ? 0 : 1;
        end
        if (m_err && m_miss >= MAX_MISS) begin
            m_mode = M_IDLE; m_miss = 0;
        end
        m_locked = (m_mode != M_IDLE);
    endfunction

    task automatic step(input bit e, input bit cr, input logic [7:0] v);
        en = e; cnt_rst = cr; value = v;
        @(posedge clk);
        model_edge(e, cr, int'(v));
        #1;
        check("locked", int'(locked), m_locked);
        check("err", int'(err), m_err);
        check("err_count", int'(err_count), m_cnt);
        check("expected", int'(expected), m_exp);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        check("first_exp", int'(first_exp), m_fexp);
        check("first_act", int'(first_act), m_fact);
`endif
    endtask

    // one edge of a well-behaved counter: value, then sync reset or increment
    task automatic cstep(input bit e, input bit cr);
        step(e, cr, 8'(ctr));
        ctr = cr ? 0 : (ctr + 1) % 256;
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_locked", int'(locked), 0);
        check("arst_err", int'(err), 0);
        check("arst_err_count", int'(err_count), 0);
        check("arst_expected", int'(expected), 0);
        #2 reset = 1'b1;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 300 && ctr != target; i++) cstep(1'b1, 1'b0);
    endtask

    initial begin
        int stuck_left;
        int stuck_val;
        bit e, cr;
        reset = 1'b0; en = 1'b0; cnt_rst = 1'b0; value = '0;
        model_reset();
        ctr = 0;
        #2;
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_expected", int'(expected), 0);
        #10 reset = 1'b1;

        // clean count through the wrap
        for (int i = 0; i < 262; i++) cstep(1'b1, 1'b0);
        check("clean_err_count", int'(err_count), 0);
        check("clean_expected", int'(expected), 6);

        // counter synchronous resets, one and two edges long
        run_to(40);
        cstep(1'b1, 1'b1);
        check("rh_expected", int'(expected), 0);
        cstep(1'b1, 1'b0);
        check("rh_release_exp", int'(expected), 1);
        for (int i = 0; i < 3; i++) cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b1);
        cstep(1'b1, 1'b1);
        cstep(1'b1, 1'b0);
        check("rh2_release_exp", int'(expected), 1);
        check("rh_err_count", int'(err_count), 0);

        // single glitch with resync
        run_to('h23);
        step(1'b1, 1'b0, 8'h40);
        ctr = 'h24;
        check("glitch_err", int'(err), 1);
        check("glitch_expected", int'(expected), 'h41);
        cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b0);
        check("glitch_err_count", int'(err_count), 2);
        check("glitch_locked", int'(locked), 1);

        // stuck counter drops lock after MAX_MISS misses, then relocks
        async_reset();
        run_to('h10);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 8'h10);
            if (i == 5) check("stuck_unlocked", int'(locked), 0);
            if (i == 6) check("stuck_relocked", int'(locked), 1);
        end
        ctr = 'h11;
        cstep(1'b1, 1'b0);
        check("stuck_err_count", int'(err_count), 4);

        // mid-run asynchronous reset, then relock with no error
        async_reset();
        for (int i = 0; i < 4; i++) cstep(1'b1, 1'b0);
        check("relock_err_count", int'(err_count), 0);

        // saturation: errors keep pulsing at the ceiling
        for (int r = 0; r < 5; r++) for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h10);
        check("sat_err_count", int'(err_count), ERR_MAX);
        step(1'b1, 1'b0, 8'h99);
        check("sat_err_pulse", int'(err), 1);

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        async_reset();
        run_to('h23);
        step(1'b1, 1'b0, 8'h40);
        ctr = 'h24;
        run_to('h50);
        step(1'b1, 1'b0, 8'h00);
        ctr = 'h51;
        cstep(1'b1, 1'b0);
        check("first_exp_val", int'(first_exp), 'h23);
        check("first_act_val", int'(first_act), 'h40);
`endif

        // randomized: enable drops, counter resets, glitches, stuck spells, async resets
        async_reset();
        stuck_left = 0;
        stuck_val  = 0;
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(15) != 0);
            cr = ($urandom_range(19) == 0);
            if (stuck_left > 0) begin
                step(e, 1'b0, 8'(stuck_val));
                stuck_left--;
            end else if ($urandom_range(24) == 0) begin
                step(e, cr, 8'($urandom_range(255)));
                ctr = cr ? 0 : (ctr + 1) % 256;
            end else if ($urandom_range(99) == 0) begin
                stuck_left = $urandom_range(8, 1);
                stuck_val  = ctr;
            end else begin
                cstep(e, cr);
            end
            if ($urandom_range(299) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
